// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling points, frame shape
// and the baud divisor, used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A   = 4'd7;
    localparam logic [3:0] SAMPLE_B   = 4'd8;
    localparam logic [3:0] SAMPLE_C   = 4'd9;
    localparam logic [3:0] OS_LAST    = 4'd15;

    localparam int DATA_BITS  = 8;
    localparam bit PARITY_EN  = 1'b1;
    localparam int TICK_CNT_W = 16;

    // Rounded clocks-per-oversample-tick for a given baud rate.
    function automatic int baud_div(input int clk, input int baud);
        return (clk + 8 * baud) / (OVERSAMPLE * baud);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator with two selectable divisors; a synchronous clear
// holds the phase at zero so ticks align to the clear's release.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_0 = 651,
    parameter int DIV_1 = 54
) (
    input  logic clock,
    input  logic reset_n,
    input  logic div_sel,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] LAST_0 = TICK_CNT_W'(DIV_0 - 1);
    localparam logic [TICK_CNT_W-1:0] LAST_1 = TICK_CNT_W'(DIV_1 - 1);

    logic [TICK_CNT_W-1:0] r_cnt;
    logic [TICK_CNT_W-1:0] w_last;
    logic                  w_wrap;

    assign w_last = div_sel ? LAST_1 : LAST_0;
    assign w_wrap = (r_cnt == w_last);
    assign tick   = w_wrap && !clear;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: 16x oversampled, 8 data bits LSB first, one parity
// bit and one stop bit, with majority voting on samples 7/8/9 of each bit.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_0     = 9600,
    parameter int BAUD_1     = 115200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_sel,
    input  logic       rx_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_bit_error,
    output logic       rx_busy,
    output logic [1:0] baud_rate
);

    localparam int DIV_0 = baud_div(CLK_FREQ, BAUD_0);
    localparam int DIV_1 = baud_div(CLK_FREQ, BAUD_1);

    rx_state_e r_state;
    rx_state_e w_next;

    logic       r_sync1, r_sync2, r_prev;
    logic       r_armed;
    logic       r_baud_sel;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_s7, r_s8;
    logic       r_pe;
    logic [7:0] r_data;
    logic       r_valid, r_perr, r_serr;

    logic w_tick, w_clear, w_start, w_vote, w_vote_now, w_bit_end;

    assign w_clear    = (r_state == IDLE);
    assign w_start    = (r_state == IDLE) && r_armed && r_prev && !r_sync2;
    assign w_vote     = maj3(r_s7, r_s8, r_sync2);
    assign w_vote_now = w_tick && (r_os_cnt == SAMPLE_C);
    assign w_bit_end  = w_tick && (r_os_cnt == OS_LAST);

    uart_baud_tick #(
        .DIV_0(DIV_0),
        .DIV_1(DIV_1)
    ) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .div_sel(r_baud_sel),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = START;
            START: begin
                if (w_vote_now && w_vote) w_next = IDLE;
                else if (w_bit_end)       w_next = DATA;
            end
            DATA:    if (w_bit_end && r_bit_idx == 3'(DATA_BITS - 1)) w_next = PARITY;
            PARITY:  if (w_bit_end) w_next = STOP;
            STOP:    if (w_vote_now) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_armed    <= 1'b1;
            r_baud_sel <= 1'b0;
            r_os_cnt   <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_pe       <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;

            // A low stop bit disarms edge detection until the line is seen high.
            if (r_state == STOP && w_vote_now && !w_vote) begin
                r_armed <= 1'b0;
            end else if (r_state == IDLE && r_sync2) begin
                r_armed <= 1'b1;
            end

            if (w_start) r_baud_sel <= baud_sel;

            if (r_state == IDLE) begin
                r_os_cnt  <= 4'd0;
                r_bit_idx <= 3'd0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
                if (w_bit_end && r_state == DATA) r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_vote_now) begin
                case (r_state)
                    PARITY: r_pe <= PARITY_EN && (w_vote != ((^r_shift) ^ PARITY_ODD));
                    STOP: begin
                        r_data  <= r_shift;
                        r_perr  <= r_pe;
                        r_serr  <= !w_vote;
                        r_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_tick && r_os_cnt == SAMPLE_A) r_s7 <= r_sync2;
        if (w_tick && r_os_cnt == SAMPLE_B) r_s8 <= r_sync2;
        if (w_vote_now && r_state == DATA) r_shift <= {w_vote, r_shift[7:1]};
    end

    assign rx_data_out    = r_data;
    assign rx_valid       = r_valid;
    assign parity_error   = r_perr;
    assign stop_bit_error = r_serr;
    assign rx_busy        = (r_state != IDLE);
    assign baud_rate      = r_baud_sel ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame, run with a scaled clock so that bit
// periods are 160 clocks (baud_sel=0) and 64 clocks (baud_sel=1).
module tb_uart_rx_frame;

    // DIV0 = (3.2M + 160k) / 320k = 10 ; DIV1 = (3.2M + 400k) / 800k = 4
    localparam int BIT0 = 160;
    localparam int BIT1 = 64;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       baud_sel = 1'b0;
    logic       rx_in    = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid, parity_error, stop_bit_error, rx_busy;
    logic [1:0] baud_rate;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int nv0, t0, w;
    logic [7:0] hist [0:31];

    typedef struct {
        logic [7:0] din;
        logic       par;
        logic       stp;
        logic       bsel;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_se;
        logic [1:0] exp_rate;
    } vec_t;

    vec_t vecs [6];

    uart_rx_frame #(
        .CLK_FREQ  (3200000),
        .BAUD_0    (20000),
        .BAUD_1    (50000),
        .PARITY_ODD(1'b0)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .baud_sel      (baud_sel),
        .rx_in         (rx_in),
        .rx_data_out   (rx_data_out),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .stop_bit_error(stop_bit_error),
        .rx_busy       (rx_busy),
        .baud_rate     (baud_rate)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) begin
            if (n_valid < 32) hist[n_valid] = rx_data_out;
            n_valid = n_valid + 1;
            last_valid_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int blen, input bit toggle);
        rx_in = 1'b0;
        wait_clk(blen);
        for (int i = 0; i < 8; i++) begin
            if (toggle && (i == 2 || i == 6)) baud_sel = ~baud_sel;
            rx_in = d[i];
            wait_clk(blen);
        end
        rx_in = p;
        wait_clk(blen);
        rx_in = s;
        wait_clk(blen);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'b10};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 2'b10};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 2'b01};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 2'b10};
        vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 2'b10};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01};

        wait_clk(4);
        chk("reset_data", rx_data_out, 8'h00);
        chk("reset_valid", rx_valid, 0);
        chk("reset_pe", parity_error, 0);
        chk("reset_se", stop_bit_error, 0);
        chk("reset_busy", rx_busy, 0);
        chk("reset_rate", baud_rate, 2'b01);
        reset_n = 1'b1;
        wait_clk(BIT0);

        for (int k = 0; k < 6; k++) begin
            baud_sel = vecs[k].bsel;
            wait_clk(4);
            nv0 = n_valid;
            t0  = cyc;
            send_frame(vecs[k].din, vecs[k].par, vecs[k].stp,
                       vecs[k].bsel ? BIT1 : BIT0, 1'b0);
            rx_in = 1'b1;
            wait_clk(2 * BIT0);
            chk($sformatf("vec%0d_valid_cnt", k), n_valid - nv0, 1);
            chk($sformatf("vec%0d_data", k), rx_data_out, vecs[k].exp_data);
            chk($sformatf("vec%0d_pe", k), parity_error, vecs[k].exp_pe);
            chk($sformatf("vec%0d_se", k), stop_bit_error, vecs[k].exp_se);
            chk($sformatf("vec%0d_rate", k), baud_rate, vecs[k].exp_rate);
            chk($sformatf("vec%0d_busy", k), rx_busy, 0);
            if (k == 0)
                chk("vec0_pulse_in_stop_bit",
                    int'((last_valid_cyc - t0 >= 10 * BIT1) && (last_valid_cyc - t0 < 11 * BIT1)), 1);
        end

        // Break: bad stop bit, then line held low for three bit times.
        baud_sel = 1'b0;
        wait_clk(4);
        nv0 = n_valid;
        send_frame(8'h81, 1'b0, 1'b0, BIT0, 1'b0);
        rx_in = 1'b0;
        wait_clk(3 * BIT0);
        chk("break_one_valid", n_valid - nv0, 1);
        chk("break_data", rx_data_out, 8'h81);
        chk("break_se", stop_bit_error, 1);
        chk("break_pe", parity_error, 0);
        chk("break_busy_low", rx_busy, 0);
        rx_in = 1'b1;
        wait_clk(2 * BIT0);
        chk("break_no_retrigger", n_valid - nv0, 1);
        send_frame(8'h55, 1'b0, 1'b1, BIT0, 1'b0);
        rx_in = 1'b1;
        wait_clk(2 * BIT0);
        chk("after_break_cnt", n_valid - nv0, 2);
        chk("after_break_data", rx_data_out, 8'h55);
        chk("after_break_pe", parity_error, 0);
        chk("after_break_se", stop_bit_error, 0);

        // Short low glitch: false start, outputs untouched.
        nv0 = n_valid;
        rx_in = 1'b0;
        wait_clk(10);
        chk("glitch_busy_rise", rx_busy, 1);
        wait_clk(20);
        rx_in = 1'b1;
        for (w = 0; w < BIT0 && rx_busy; w++) @(negedge clock);
        chk("glitch_busy_fall", rx_busy, 0);
        wait_clk(2 * BIT0);
        chk("glitch_no_valid", n_valid - nv0, 0);
        chk("glitch_data", rx_data_out, 8'h55);
        chk("glitch_pe", parity_error, 0);
        chk("glitch_se", stop_bit_error, 0);

        // Back-to-back frames, baud_sel toggled during the first.
        baud_sel = 1'b0;
        wait_clk(4);
        nv0 = n_valid;
        send_frame(8'h00, 1'b0, 1'b1, BIT0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, BIT0, 1'b0);
        rx_in = 1'b1;
        wait_clk(2 * BIT0);
        chk("b2b_cnt", n_valid - nv0, 2);
        chk("b2b_first", hist[nv0], 8'h00);
        chk("b2b_second", hist[nv0 + 1], 8'hFF);
        chk("b2b_pe", parity_error, 0);
        chk("b2b_se", stop_bit_error, 0);
        chk("b2b_rate", baud_rate, 2'b01);

        // Reset pulse during data bit 4 of 0x7E.
        baud_sel = 1'b1;
        wait_clk(4);
        nv0 = n_valid;
        rx_in = 1'b0; wait_clk(BIT1);
        rx_in = 1'b0; wait_clk(BIT1);
        rx_in = 1'b1; wait_clk(BIT1);
        rx_in = 1'b1; wait_clk(BIT1);
        rx_in = 1'b1; wait_clk(BIT1);
        rx_in = 1'b1; wait_clk(BIT1 / 2);
        chk("pre_reset_busy", rx_busy, 1);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        chk("midreset_data", rx_data_out, 8'h00);
        chk("midreset_valid", rx_valid, 0);
        chk("midreset_pe", parity_error, 0);
        chk("midreset_se", stop_bit_error, 0);
        chk("midreset_busy", rx_busy, 0);
        chk("midreset_rate", baud_rate, 2'b01);
        wait_clk(12 * BIT1);
        chk("midreset_no_valid", n_valid - nv0, 0);
        send_frame(8'h7E, 1'b0, 1'b1, BIT1, 1'b0);
        rx_in = 1'b1;
        wait_clk(2 * BIT1);
        chk("post_reset_cnt", n_valid - nv0, 1);
        chk("post_reset_data", rx_data_out, 8'h7E);
        chk("post_reset_pe", parity_error, 0);
        chk("post_reset_se", stop_bit_error, 0);
        chk("post_reset_rate", baud_rate, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
